// File: rtl/axi_tlb_lookup_arb.sv
// Round-robin arbiter sharing one TLB lookup engine between the AW and AR
// translation streams, with an order FIFO that steers in-order results back.
module axi_tlb_lookup_arb #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned ResWidth   = 33,
    parameter int unsigned MaxPending = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [AddrWidth-1:0]              wr_req_addr_i,
    input  logic                              wr_req_valid_i,
    output logic                              wr_req_ready_o,
    output logic [ResWidth-1:0]               wr_res_o,
    output logic                              wr_res_valid_o,
    input  logic                              wr_res_ready_i,
    input  logic [AddrWidth-1:0]              rd_req_addr_i,
    input  logic                              rd_req_valid_i,
    output logic                              rd_req_ready_o,
    output logic [ResWidth-1:0]               rd_res_o,
    output logic                              rd_res_valid_o,
    input  logic                              rd_res_ready_i,
    output logic [AddrWidth-1:0]              lkp_req_addr_o,
    output logic                              lkp_req_valid_o,
    input  logic                              lkp_req_ready_i,
    input  logic [ResWidth-1:0]               lkp_res_i,
    input  logic                              lkp_res_valid_i,
    output logic                              lkp_res_ready_o,
    output logic [$clog2(MaxPending+1)-1:0]   pending_o,
    output logic                              busy_o
);

    localparam int unsigned CntWidth = $clog2(MaxPending + 1);
    localparam int unsigned PtrWidth = (MaxPending > 1) ? $clog2(MaxPending) : 1;
    localparam logic        DirWr    = 1'b0;
    localparam logic        DirRd    = 1'b1;

    logic [CntWidth-1:0]   count_q, count_d;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [MaxPending-1:0] dir_fifo_q, dir_fifo_d;
    logic                  prio_q, prio_d;
    logic                  lock_q, lock_d;
    logic                  lock_dir_q, lock_dir_d;

    logic full, empty, gnt_dir, head_dir, req_hs, res_hs;

    function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
        if (p == PtrWidth'(MaxPending - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // A locked grant wins over the round-robin choice so a stalled request stays stable.
    always_comb begin
        full  = (count_q == CntWidth'(MaxPending));
        empty = (count_q == '0);
        if (lock_q) begin
            gnt_dir = lock_dir_q;
        end else if (wr_req_valid_i && rd_req_valid_i) begin
            gnt_dir = prio_q;
        end else if (rd_req_valid_i) begin
            gnt_dir = DirRd;
        end else if (wr_req_valid_i) begin
            gnt_dir = DirWr;
        end else begin
            gnt_dir = prio_q;
        end
    end

    always_comb begin
        lkp_req_valid_o = !full && ((gnt_dir == DirRd) ? rd_req_valid_i : wr_req_valid_i);
        lkp_req_addr_o  = (gnt_dir == DirRd) ? rd_req_addr_i : wr_req_addr_i;
        wr_req_ready_o  = !full && (gnt_dir == DirWr) && lkp_req_ready_i;
        rd_req_ready_o  = !full && (gnt_dir == DirRd) && lkp_req_ready_i;
        req_hs          = lkp_req_valid_o && lkp_req_ready_i;

        head_dir        = dir_fifo_q[rd_ptr_q];
        wr_res_o        = lkp_res_i;
        rd_res_o        = lkp_res_i;
        wr_res_valid_o  = !empty && (head_dir == DirWr) && lkp_res_valid_i;
        rd_res_valid_o  = !empty && (head_dir == DirRd) && lkp_res_valid_i;
        lkp_res_ready_o = !empty && ((head_dir == DirRd) ? rd_res_ready_i : wr_res_ready_i);
        res_hs          = lkp_res_valid_i && lkp_res_ready_o;

        pending_o       = count_q;
        busy_o          = (count_q != '0) || lkp_req_valid_o;
    end

    always_comb begin
        lock_d     = lkp_req_valid_o && !lkp_req_ready_i;
        lock_dir_d = gnt_dir;
        prio_d     = req_hs ? ~gnt_dir : prio_q;
        dir_fifo_d = dir_fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (req_hs) begin
            dir_fifo_d[wr_ptr_q] = gnt_dir;
            wr_ptr_d             = ptr_next(wr_ptr_q);
        end
        if (res_hs) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (req_hs && !res_hs) begin
            count_d = count_q + 1'b1;
        end else if (!req_hs && res_hs) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dir_fifo_q <= '0;
            prio_q     <= DirWr;
            lock_q     <= 1'b0;
            lock_dir_q <= DirWr;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dir_fifo_q <= dir_fifo_d;
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_dir_q <= lock_dir_d;
        end
    end

`ifndef SYNTHESIS
    max_pending_nonzero: assert property (@(posedge clk_i) MaxPending != 0)
        else $error("MaxPending must be at least 1");
    wr_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wr_req_valid_i && !wr_req_ready_o) |=> (wr_req_valid_i && $stable(wr_req_addr_i)))
        else $error("write request dropped or changed before ready");
    rd_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rd_req_valid_i && !rd_req_ready_o) |=> (rd_req_valid_i && $stable(rd_req_addr_i)))
        else $error("read request dropped or changed before ready");
    res_without_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lkp_res_valid_i |-> !empty)
        else $error("engine returned a result with no lookup outstanding");
    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_hs |-> !full)
        else $error("order FIFO overflow");
    fifo_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        res_hs |-> !empty)
        else $error("order FIFO underflow");
`endif

endmodule

// File: tb/tb_axi_tlb_lookup_arb.sv
// Bench for axi_tlb_lookup_arb: directed vector table, corner-case sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_axi_tlb_lookup_arb;

    typedef struct {
        logic        wv;
        logic [31:0] wa;
        logic        rv;
        logic [31:0] ra;
        logic        lrdy;
        logic        resv;
        logic [32:0] res;
        logic        wrr;
        logic        rrr;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        lv;
        logic [31:0] la;
        logic        wrdy;
        logic        rrdy;
        logic        wresv;
        logic        rresv;
        logic        lresrdy;
        int          pend;
    } vec_t;

    localparam logic [31:0] WA    = 32'h0000_A000;
    localparam logic [31:0] RA    = 32'h0000_B000;
    localparam logic [32:0] RES_W = 33'h1_0000_A000;
    localparam logic [32:0] RES_R = 33'h1_0000_B000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] wr_req_addr_i = '0;
    logic        wr_req_valid_i = 1'b0;
    logic        wr_req_ready_o;
    logic [32:0] wr_res_o;
    logic        wr_res_valid_o;
    logic        wr_res_ready_i = 1'b0;
    logic [31:0] rd_req_addr_i = '0;
    logic        rd_req_valid_i = 1'b0;
    logic        rd_req_ready_o;
    logic [32:0] rd_res_o;
    logic        rd_res_valid_o;
    logic        rd_res_ready_i = 1'b0;
    logic [31:0] lkp_req_addr_o;
    logic        lkp_req_valid_o;
    logic        lkp_req_ready_i = 1'b0;
    logic [32:0] lkp_res_i = '0;
    logic        lkp_res_valid_i = 1'b0;
    logic        lkp_res_ready_o;
    logic [2:0]  pending_o;
    logic        busy_o;

    int n_vec  = 0;
    int n_miss = 0;

    axi_tlb_lookup_arb #(
        .AddrWidth (32),
        .ResWidth  (33),
        .MaxPending(4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .wr_req_addr_i  (wr_req_addr_i),
        .wr_req_valid_i (wr_req_valid_i),
        .wr_req_ready_o (wr_req_ready_o),
        .wr_res_o       (wr_res_o),
        .wr_res_valid_o (wr_res_valid_o),
        .wr_res_ready_i (wr_res_ready_i),
        .rd_req_addr_i  (rd_req_addr_i),
        .rd_req_valid_i (rd_req_valid_i),
        .rd_req_ready_o (rd_req_ready_o),
        .rd_res_o       (rd_res_o),
        .rd_res_valid_o (rd_res_valid_o),
        .rd_res_ready_i (rd_res_ready_i),
        .lkp_req_addr_o (lkp_req_addr_o),
        .lkp_req_valid_o(lkp_req_valid_o),
        .lkp_req_ready_i(lkp_req_ready_i),
        .lkp_res_i      (lkp_res_i),
        .lkp_res_valid_i(lkp_res_valid_i),
        .lkp_res_ready_o(lkp_res_ready_o),
        .pending_o      (pending_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic wv, input logic [31:0] wa, input logic rv,
                                input logic [31:0] ra, input logic lrdy, input logic resv,
                                input logic [32:0] res, input logic wrr, input logic rrr,
                                input logic lv, input logic [31:0] la, input logic wrdy,
                                input logic rrdy, input logic wresv, input logic rresv,
                                input logic lresrdy, input int pend);
        vec_t v;
        v.s.wv = wv;   v.s.wa = wa;     v.s.rv = rv;   v.s.ra = ra;
        v.s.lrdy = lrdy; v.s.resv = resv; v.s.res = res;
        v.s.wrr = wrr; v.s.rrr = rrr;
        v.lv = lv;     v.la = la;       v.wrdy = wrdy; v.rrdy = rrdy;
        v.wresv = wresv; v.rresv = rresv; v.lresrdy = lresrdy; v.pend = pend;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        wr_req_valid_i  = s.wv;
        wr_req_addr_i   = s.wa;
        rd_req_valid_i  = s.rv;
        rd_req_addr_i   = s.ra;
        lkp_req_ready_i = s.lrdy;
        lkp_res_valid_i = s.resv;
        lkp_res_i       = s.res;
        wr_res_ready_i  = s.wrr;
        rd_res_ready_i  = s.rrr;
        #2;
    endtask

    task automatic checkVec(input string tag, input vec_t e, input bit strict);
        checkOutput({tag, " lkp_req_valid"}, 64'(lkp_req_valid_o), 64'(e.lv));
        if (e.lv) checkOutput({tag, " lkp_req_addr"}, 64'(lkp_req_addr_o), 64'(e.la));
        if (strict || e.s.wv) checkOutput({tag, " wr_req_ready"}, 64'(wr_req_ready_o), 64'(e.wrdy));
        if (strict || e.s.rv) checkOutput({tag, " rd_req_ready"}, 64'(rd_req_ready_o), 64'(e.rrdy));
        checkOutput({tag, " wr_res_valid"}, 64'(wr_res_valid_o), 64'(e.wresv));
        checkOutput({tag, " rd_res_valid"}, 64'(rd_res_valid_o), 64'(e.rresv));
        checkOutput({tag, " lkp_res_ready"}, 64'(lkp_res_ready_o), 64'(e.lresrdy));
        checkOutput({tag, " pending"}, 64'(pending_o), 64'(e.pend));
        checkOutput({tag, " busy"}, 64'(busy_o), 64'((e.pend != 0) || e.lv));
        if (e.wresv) checkOutput({tag, " wr_res"}, 64'(wr_res_o), 64'(e.s.res));
        if (e.rresv) checkOutput({tag, " rd_res"}, 64'(rd_res_o), 64'(e.s.res));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic runVec(input string tag, input vec_t v, input bit strict);
        applyStimulus(v.s);
        checkVec(tag, v, strict);
        step();
    endtask

    vec_t tbl[$];

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single write, contention, fill to MaxPending, lock while full-adjacent, drain.
        tbl.push_back(idle);
        tbl.push_back(mk(1, 32'h1000, 0, 0, 1, 0, 0, 1, 1, 1, 32'h1000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 33'h1_8000_1000, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(idle);
        tbl.push_back(mk(1, WA, 1, RA, 1, 0, 0,     1, 1, 1, RA, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, WA, 1, RA, 1, 1, RES_R, 1, 1, 1, WA, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, WA, 1, RA, 1, 1, RES_W, 1, 1, 1, RA, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(1, WA, 1, RA, 1, 0, 0,     1, 1, 1, WA, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, WA, 1, RA, 1, 0, 0,     1, 1, 1, RA, 0, 1, 0, 0, 1, 2));
        tbl.push_back(mk(1, WA, 1, RA, 1, 0, 0,     1, 1, 1, WA, 1, 0, 0, 0, 1, 3));
        tbl.push_back(mk(1, WA, 1, RA, 1, 1, RES_R, 1, 1, 0, 0,  0, 0, 0, 1, 1, 4));
        tbl.push_back(mk(1, WA, 1, RA, 1, 0, 0,     1, 1, 1, RA, 0, 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, WA, 1, RA, 1, 1, RES_W, 1, 1, 0, 0,  0, 0, 1, 0, 1, 4));
        tbl.push_back(mk(1, WA, 1, RA, 0, 1, RES_R, 1, 1, 1, WA, 0, 0, 0, 1, 1, 3));
        tbl.push_back(mk(1, WA, 1, RA, 1, 1, RES_W, 1, 1, 1, WA, 1, 0, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0,  1, RA, 1, 1, RES_R, 1, 1, 1, RA, 0, 1, 0, 1, 1, 2));
        tbl.push_back(mk(0, 0,  0, 0,  0, 1, RES_W, 1, 1, 0, 0,  0, 0, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0,  0, 0,  0, 1, RES_R, 1, 1, 0, 0,  0, 0, 0, 1, 1, 1));
        tbl.push_back(idle);

        applyStimulus(idle.s);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            runVec($sformatf("tbl[%0d]", i), tbl[i], 1'b1);
        end

        // Engine stalls with read granted; a higher-priority write must not steal the grant.
        runVec("lock1", mk(0, 0,  1, RA, 0, 0, 0, 1, 1, 1, RA, 0, 0, 0, 0, 0, 0), 1'b1);
        runVec("lock2", mk(1, WA, 1, RA, 0, 0, 0, 1, 1, 1, RA, 0, 0, 0, 0, 0, 0), 1'b1);
        runVec("lock3", mk(1, WA, 1, RA, 0, 0, 0, 1, 1, 1, RA, 0, 0, 0, 0, 0, 0), 1'b1);
        runVec("lock4", mk(1, WA, 1, RA, 1, 0, 0, 1, 1, 1, RA, 0, 1, 0, 0, 0, 0), 1'b1);
        runVec("lock5", mk(1, WA, 0, 0,  1, 0, 0, 1, 1, 1, WA, 1, 0, 0, 0, 1, 1), 1'b1);
        runVec("lock6", mk(0, 0, 0, 0, 0, 1, RES_R, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2), 1'b1);
        runVec("lock7", mk(0, 0, 0, 0, 0, 1, RES_W, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1), 1'b1);
        runVec("lock8", idle, 1'b1);

        // Head-of-line: read result waits behind an unconsumed write result.
        runVec("hol1", mk(1, WA, 0, 0,  1, 0, 0, 1, 1, 1, WA, 1, 0, 0, 0, 0, 0), 1'b1);
        runVec("hol2", mk(0, 0,  1, RA, 1, 0, 0, 1, 1, 1, RA, 0, 1, 0, 0, 1, 1), 1'b1);
        for (int i = 0; i < 5; i++) begin
            runVec($sformatf("hol_stall%0d", i),
                   mk(0, 0, 0, 0, 0, 1, RES_W, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2), 1'b1);
        end
        runVec("hol3", mk(0, 0, 0, 0, 0, 1, RES_W, 1, 1, 0, 0, 0, 0, 1, 0, 1, 2), 1'b1);
        runVec("hol4", mk(0, 0, 0, 0, 0, 1, RES_R, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1), 1'b1);
        runVec("hol5", idle, 1'b1);

        // Reset with three lookups outstanding and priority left on read.
        runVec("rst1", mk(1, WA, 0, 0,  1, 0, 0, 1, 1, 1, WA, 1, 0, 0, 0, 0, 0), 1'b1);
        runVec("rst2", mk(0, 0,  1, RA, 1, 0, 0, 1, 1, 1, RA, 0, 1, 0, 0, 1, 1), 1'b1);
        runVec("rst3", mk(1, WA, 0, 0,  1, 0, 0, 1, 1, 1, WA, 1, 0, 0, 0, 1, 2), 1'b1);
        checkOutput("rst pending before", 64'(pending_o), 64'd3);
        rst_ni = 1'b0;
        applyStimulus(idle.s);
        checkVec("rst_async", idle, 1'b1);
        step();
        step();
        rst_ni = 1'b1;
        runVec("rst5", mk(1, WA, 1, RA, 1, 0, 0, 1, 1, 1, WA, 1, 0, 0, 0, 0, 0), 1'b1);
        runVec("rst6", mk(0, 0,  1, RA, 1, 0, 0, 1, 1, 1, RA, 0, 1, 0, 0, 1, 1), 1'b1);
        runVec("rst7", mk(0, 0, 0, 0, 0, 1, RES_W, 1, 1, 0, 0, 0, 0, 1, 0, 1, 2), 1'b1);
        runVec("rst8", mk(0, 0, 0, 0, 0, 1, RES_R, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1), 1'b1);
        runVec("rst9", idle, 1'b1);

        // Random traffic: requesters hold requests until accepted, engine answers in order.
        begin
            int          q_dir[$];
            logic [31:0] q_addr[$];
            int          m_prio = 0;
            int          m_held = -1;
            bit          m_wv = 0;
            bit          m_rv = 0;
            logic [31:0] m_wa = '0;
            logic [31:0] m_ra = '0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                vec_t e;
                bit   full;
                int   g;
                int   head;
                if (!m_wv && $urandom_range(0, 99) < 55) begin
                    m_wv = 1;
                    m_wa = $urandom;
                end
                if (!m_rv && $urandom_range(0, 99) < 55) begin
                    m_rv = 1;
                    m_ra = $urandom;
                end
                e.s.wv   = m_wv;
                e.s.wa   = m_wv ? m_wa : $urandom;
                e.s.rv   = m_rv;
                e.s.ra   = m_rv ? m_ra : $urandom;
                e.s.lrdy = ($urandom_range(0, 99) < 65);
                e.s.resv = (q_dir.size() > 0) && ($urandom_range(0, 99) < 55);
                e.s.res  = (q_dir.size() > 0) ? {1'b1, q_addr[0] ^ 32'h0F0F_0000} : {1'b0, $urandom};
                e.s.wrr  = ($urandom_range(0, 99) < 70);
                e.s.rrr  = ($urandom_range(0, 99) < 70);

                full = (q_dir.size() >= 4);
                if (m_held >= 0)        g = m_held;
                else if (m_wv && m_rv)  g = m_prio;
                else if (m_wv)          g = 0;
                else if (m_rv)          g = 1;
                else                    g = -1;
                e.lv   = !full && (g >= 0);
                e.la   = (g == 1) ? m_ra : m_wa;
                e.wrdy = e.lv && (g == 0) && e.s.lrdy;
                e.rrdy = e.lv && (g == 1) && e.s.lrdy;
                if (q_dir.size() > 0) begin
                    head      = q_dir[0];
                    e.wresv   = e.s.resv && (head == 0);
                    e.rresv   = e.s.resv && (head == 1);
                    e.lresrdy = (head == 1) ? e.s.rrr : e.s.wrr;
                end else begin
                    e.wresv   = 1'b0;
                    e.rresv   = 1'b0;
                    e.lresrdy = 1'b0;
                end
                e.pend = q_dir.size();

                runVec($sformatf("rnd[%0d]", cyc), e, 1'b0);

                if ((e.wresv || e.rresv) && e.lresrdy) begin
                    void'(q_dir.pop_front());
                    void'(q_addr.pop_front());
                end
                if (e.lv && e.s.lrdy) begin
                    q_dir.push_back(g);
                    q_addr.push_back(e.la);
                    m_prio = (g == 0) ? 1 : 0;
                    m_held = -1;
                    if (g == 0) m_wv = 0;
                    else        m_rv = 0;
                end else if (e.lv) begin
                    m_held = g;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/axi_tlb_lookup_arb.md
Name: axi_tlb_lookup_arb

Overview:
- Shares one TLB lookup engine between the write-address (AW) and read-address (AR) translation request streams of the AXI TLB.
- Arbitrates the two requesters round-robin and issues one lookup at a time to the shared engine.
- Records the direction of every issued lookup in an order FIFO, and routes each in-order lookup result back to the requester that issued it.
- Sits between the slave-port AW/AR forks and a single-ported L1 TLB lookup stage.

Parameters:
- AddrWidth, 32, width of the lookup (input) address.
- ResWidth, 33, width of a lookup result ({hit, translated address}); passed through opaquely.
- MaxPending, 4, maximum number of issued lookups not yet answered; order FIFO depth; must be >= 1.

Ports:
- clk_i  in  1  rising-edge clock
- rst_ni  in  1  asynchronous reset, active low
- wr_req_addr_i  in  AddrWidth  write lookup address
- wr_req_valid_i  in  1  write lookup request valid
- wr_req_ready_o  out  1  write lookup request accepted
- wr_res_o  out  ResWidth  write lookup result
- wr_res_valid_o  out  1  write result valid
- wr_res_ready_i  in  1  write result consumed
- rd_req_addr_i  in  AddrWidth  read lookup address
- rd_req_valid_i  in  1  read lookup request valid
- rd_req_ready_o  out  1  read lookup request accepted
- rd_res_o  out  ResWidth  read lookup result
- rd_res_valid_o  out  1  read result valid
- rd_res_ready_i  in  1  read result consumed
- lkp_req_addr_o  out  AddrWidth  address to the shared lookup engine
- lkp_req_valid_o  out  1  lookup request valid
- lkp_req_ready_i  in  1  engine accepts the request
- lkp_res_i  in  ResWidth  engine result (returned in issue order)
- lkp_res_valid_i  in  1  engine result valid
- lkp_res_ready_o  out  1  result accepted
- pending_o  out  $clog2(MaxPending+1)  number of outstanding lookups
- busy_o  out  1  pending_o != 0 or lkp_req_valid_o

Behaviour:
- Reset:
  - Order FIFO empty; pending_o = 0.
  - Round-robin priority points to write.
  - Grant lock cleared.
  - All valid/ready outputs 0.
- Issue eligibility: a lookup may be issued only when the FIFO is not full (pending < MaxPending).
  - When full, lkp_req_valid_o = 0 and both req_ready_o = 0.
  - A pop in the same cycle does not free a slot until the next cycle.
- Arbitration (combinational when unlocked):
  - If only one requester is valid, it is granted.
  - If both are valid, the one with priority is granted.
- Request path:
  - lkp_req_valid_o = granted requester's valid.
  - lkp_req_addr_o = granted requester's address.
  - Granted requester's req_ready_o = lkp_req_ready_i; the other requester's ready = 0.
- Priority update: on each lookup handshake, priority moves to the non-granted direction, so back-to-back contention alternates W,R,W,R.
- Grant lock:
  - If lkp_req_valid_o = 1 and lkp_req_ready_i = 0, the grant is registered and held until the handshake.
  - While locked, a newly valid higher-priority requester does not change the grant.
  - This keeps lkp_req_valid_o and lkp_req_addr_o stable. The lock releases on handshake.
- Order FIFO:
  - On each lookup handshake, push a direction bit (0 = write, 1 = read).
  - pending increments on push and decrements on pop; a simultaneous push and pop leaves it unchanged.
- Response path (zero latency, combinational):
  - When the FIFO is non-empty, lkp_res_i and lkp_res_valid_i are steered to the head direction's res_o/res_valid_o, and lkp_res_ready_o = that direction's res_ready_i.
  - The other direction's res_valid_o = 0.
  - res_o of both directions may always carry lkp_res_i.
  - Pop on the lkp_res handshake.
- Empty FIFO:
  - lkp_res_ready_o = 0 and both res_valid_o = 0.
  - lkp_res_valid_i = 1 while empty is an engine protocol violation; a simulation assertion fires.
- A response may be issued in the same cycle as its request handshake only after the push is visible, i.e. the earliest response is in the cycle after the request handshake.
- Back-pressure on one result output stalls all later results, in order (head-of-line).
- Asynchronous reset mid-operation: immediate return to reset state; outstanding lookups are discarded. The engine must be reset concurrently.
- Assertions: MaxPending >= 1; request valid/addr stable until ready, for each requester; no FIFO overflow or underflow.

Test Plan:
- Single write, 0x1000, engine ready; result 0x1_8000_1000 one cycle later:
  - lkp_req_addr_o = 0x1000.
  - wr_res_valid_o = 1 with that result; rd_res_valid_o = 0.
  - pending_o goes 1 then 0.
- Both requesters continuously valid (wr 0xA000, rd 0xB000), engine always ready:
  - Issue order W,R,W,R starting with W after reset.
  - Results are routed alternately to wr_res and rd_res.
- Engine stalls (lkp_req_ready_i = 0 for 3 cycles) while the read request is granted; write becomes valid meanwhile:
  - Grant stays on read; lkp_req_addr_o is unchanged for all 3 cycles.
  - Write is issued next.
- MaxPending = 4, engine accepts requests but withholds results:
  - After 4 issues, both req_ready_o = 0 and pending_o = 4.
  - Returning one result re-enables issue from the following cycle.
- Issue W then R; hold wr_res_ready_i = 0 for 5 cycles:
  - The read result is not delivered until the write result is consumed.
  - lkp_res_ready_o = 0 during the stall.
- Assert rst_ni low with 3 lookups pending:
  - pending_o = 0 and all valids = 0 immediately.
  - After release, the first contended grant goes to write.
